// File: rtl/ysyx_25040111_arb_pkg.sv
// Shared types for the icache/LSU memory bus arbiter.
// State encoding, requester indices, response codes, latched request.
package ysyx_25040111_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  localparam int IDX_IC = 0;
  localparam int IDX_LS = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        g;
  } req_t;

endpackage

// File: rtl/ysyx_25040111_rr2.sv
// Two-input round-robin picker.
// Ports: valid[1:0] requests, last = previous winner, grant one-hot.
module ysyx_25040111_rr2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie the winner is the index opposite the last grant.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11)
      grant = last ? 2'b01 : 2'b10;
    else
      grant = valid;
  end

endmodule

// File: rtl/ysyx_25040111_mem_arb.sv
// Icache/LSU arbiter onto one AXI4-style master, one txn in flight.
// Ports: req_* from requesters, rsp_* back, m_* downstream AR/R/AW/W/B.
module ysyx_25040111_mem_arb
  import ysyx_25040111_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [1:0]  rsp_valid,
  output logic        rsp_err,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp
);

  state_t     state;
  req_t       req_q;
  logic       last_grant;
  logic [7:0] beat_cnt;
  logic       aw_done;
  logic       w_done;

  logic [1:0] grant;
  logic       accept;
  logic       sel_ls;
  logic       rd_beat;
  logic       wr_rsp;
  logic       len_bad;
  logic       aw_nx;
  logic       w_nx;

  // Read data goes straight to the requesters; the icache
  // never writes, so its write bit has no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, req_write[IDX_IC], m_rdata};

  ysyx_25040111_rr2 u_rr2 (
    .valid (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // Gated by the reset net so nothing is offered while held.
  assign req_ready =
    (reset && state == IDLE) ? grant : 2'b00;
  assign accept = |(req_ready & req_valid);
  assign sel_ls = grant[IDX_LS];

  assign m_arvalid = (state == RD_ADDR);
  assign m_araddr  = req_q.addr;
  assign m_arlen   = req_q.len;
  assign m_rready  = (state == RD_DATA);
  assign m_awvalid = (state == WR_REQ) && !aw_done;
  assign m_wvalid  = (state == WR_REQ) && !w_done;
  assign m_awaddr  = req_q.addr;
  assign m_wdata   = req_q.wdata;
  assign m_wstrb   = req_q.wstrb;
  assign m_bready  = (state == WR_RESP);

  assign rd_beat = m_rready && m_rvalid;
  assign wr_rsp  = m_bready && m_bvalid;

  // A last beat arriving at the wrong count is flagged.
  assign len_bad = m_rlast && (beat_cnt != req_q.len);

  assign aw_nx = aw_done || m_awready;
  assign w_nx  = w_done || m_wready;

  always_comb begin
    rsp_valid = 2'b00;
    rsp_err   = 1'b0;
    if (rd_beat) begin
      rsp_valid[req_q.g] = 1'b1;
      rsp_err = (m_rresp != RESP_OKAY) || len_bad;
    end else if (wr_rsp) begin
      rsp_valid[IDX_LS] = 1'b1;
      rsp_err = (m_bresp != RESP_OKAY);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_q      <= '0;
      last_grant <= 1'b0;
      beat_cnt   <= 8'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_q.addr  <= sel_ls ? req_addr[63:32]
                                  : req_addr[31:0];
            req_q.len   <= sel_ls ? 8'd0 : req_len;
            req_q.wdata <= req_wdata;
            req_q.wstrb <= req_wstrb;
            req_q.g     <= sel_ls;
            state <= (sel_ls && req_write[IDX_LS])
                     ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            beat_cnt <= 8'd0;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_rlast) begin
              last_grant <= req_q.g;
              state      <= IDLE;
            end
          end
        end
        WR_REQ: begin
          // AW and W may finish in either order or together.
          if (aw_nx && w_nx) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_nx;
            w_done  <= w_nx;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            last_grant <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
